// File: rtl/alkmdseq.sv
// alkmdseq: multiply/divide step sequencer for the ALK slice.
// Sequences PRE, N STEP iterations and an optional REM FIX cycle, then DONE.
// All outputs are registered and decoded from the next state.
module alkmdseq #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_h,
  input  logic             reset_h,
  input  logic             start_h,
  input  logic [1:0]       op_h,
  input  logic [1:0]       dsize_h,
  input  logic             stall_h,
  input  logic             alu_sign_h,
  output logic             alpctl_mul_l,
  output logic             alpctl_div_l,
  output logic             alpctl_divdbl_l,
  output logic             alpctl_rem_l,
  output logic             dq_q_shl_l,
  output logic             dq_q_shr_l,
  output logic             alushf_force_sout0_h,
  output logic             alu_sub_h,
  output logic             busy_h,
  output logic             done_h,
  output logic [CNT_W-1:0] step_cnt_h
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_STEP = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_DIV    = 2'b01;
  localparam logic [1:0] OP_DIVDBL = 2'b10;
  localparam logic [1:0] OP_REM    = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_d;
  logic             stall_act;
  logic             mul_d, div_d, divdbl_d, rem_d;
  logic             shl_d, shr_d, force_d, sub_d, busy_d, done_d;

  // Next state, counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = step_cnt_h;
    mul_d     = 1'b1;
    div_d     = 1'b1;
    divdbl_d  = 1'b1;
    rem_d     = 1'b1;
    shl_d     = 1'b1;
    shr_d     = 1'b1;
    force_d   = 1'b0;
    sub_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    stall_act = stall_h && ((state_q == S_PRE) || (state_q == S_STEP) || (state_q == S_FIX));

    case (state_q)
      S_IDLE: begin
        if (start_h) begin
          state_d = S_PRE;
          op_d    = op_h;
          case (dsize_h)
            2'b00:   cnt_d = CNT_W'(7);
            2'b01:   cnt_d = CNT_W'(15);
            default: cnt_d = CNT_W'(31);
          endcase
        end
      end
      S_PRE: begin
        if (!stall_act) state_d = S_STEP;
      end
      S_STEP: begin
        if (!stall_act) begin
          if (step_cnt_h == '0) begin
            state_d = (op_q == OP_REM) ? S_FIX : S_DONE;
          end else begin
            cnt_d = step_cnt_h - CNT_W'(1);
          end
        end
      end
      S_FIX: begin
        if (!stall_act) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (stall_act) begin
      // Frozen cycle: controls quiet, add/subtract (sign history) held.
      busy_d = 1'b1;
      sub_d  = alu_sub_h;
    end else begin
      busy_d  = (state_d == S_PRE) || (state_d == S_STEP) || (state_d == S_FIX);
      done_d  = (state_d == S_DONE);
      force_d = (state_d == S_PRE);
      if ((state_d == S_PRE) || (state_d == S_STEP)) begin
        case (op_d)
          OP_MUL:    mul_d = 1'b0;
          OP_DIVDBL: begin
            div_d    = 1'b0;
            divdbl_d = 1'b0;
          end
          default:   div_d = 1'b0;
        endcase
      end
      if (state_d == S_STEP) begin
        if (op_d == OP_MUL) begin
          shr_d = 1'b0;
        end else begin
          shl_d = 1'b0;
          // Non-restoring: first iteration subtracts, then follows last sign.
          sub_d = (state_q == S_PRE) ? 1'b1 : ~alu_sign_h;
        end
      end
      if (state_d == S_FIX) begin
        rem_d = 1'b0;
        sub_d = ~alu_sign_h;
      end
    end
  end

  // State, latched operation and output registers.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      state_q              <= S_IDLE;
      op_q                 <= OP_MUL;
      step_cnt_h           <= '0;
      alpctl_mul_l         <= 1'b1;
      alpctl_div_l         <= 1'b1;
      alpctl_divdbl_l      <= 1'b1;
      alpctl_rem_l         <= 1'b1;
      dq_q_shl_l           <= 1'b1;
      dq_q_shr_l           <= 1'b1;
      alushf_force_sout0_h <= 1'b0;
      alu_sub_h            <= 1'b0;
      busy_h               <= 1'b0;
      done_h               <= 1'b0;
    end else begin
      state_q              <= state_d;
      op_q                 <= op_d;
      step_cnt_h           <= cnt_d;
      alpctl_mul_l         <= mul_d;
      alpctl_div_l         <= div_d;
      alpctl_divdbl_l      <= divdbl_d;
      alpctl_rem_l         <= rem_d;
      dq_q_shl_l           <= shl_d;
      dq_q_shr_l           <= shr_d;
      alushf_force_sout0_h <= force_d;
      alu_sub_h            <= sub_d;
      busy_h               <= busy_d;
      done_h               <= done_d;
    end
  end

endmodule

// File: tb/tb_alkmdseq.sv
// Directed bench for alkmdseq: a per-cycle vector table plus hand-written sequences.
module tb_alkmdseq;

  localparam int unsigned CNT_W = 6;
  localparam logic [15:0] FULL  = 16'hFFFF;
  localparam logic [15:0] NOSUB = 16'hFEFF;

  logic             clk_h;
  logic             reset_h, start_h, stall_h, alu_sign_h;
  logic [1:0]       op_h, dsize_h;
  logic             alpctl_mul_l, alpctl_div_l, alpctl_divdbl_l, alpctl_rem_l;
  logic             dq_q_shl_l, dq_q_shr_l, alushf_force_sout0_h, alu_sub_h;
  logic             busy_h, done_h;
  logic [CNT_W-1:0] step_cnt_h;
  logic [15:0]      obs;

  int n_checks;
  int n_fail;

  alkmdseq #(.CNT_W(CNT_W)) dut (
    .clk_h(clk_h), .reset_h(reset_h), .start_h(start_h), .op_h(op_h),
    .dsize_h(dsize_h), .stall_h(stall_h), .alu_sign_h(alu_sign_h),
    .alpctl_mul_l(alpctl_mul_l), .alpctl_div_l(alpctl_div_l),
    .alpctl_divdbl_l(alpctl_divdbl_l), .alpctl_rem_l(alpctl_rem_l),
    .dq_q_shl_l(dq_q_shl_l), .dq_q_shr_l(dq_q_shr_l),
    .alushf_force_sout0_h(alushf_force_sout0_h), .alu_sub_h(alu_sub_h),
    .busy_h(busy_h), .done_h(done_h), .step_cnt_h(step_cnt_h)
  );

  // Bit layout: [15:12] mul,div,divdbl,rem  [11:10] shl,shr  [9] force  [8] sub  [7] busy  [6] done  [5:0] cnt
  assign obs = {alpctl_mul_l, alpctl_div_l, alpctl_divdbl_l, alpctl_rem_l,
                dq_q_shl_l, dq_q_shr_l, alushf_force_sout0_h, alu_sub_h,
                busy_h, done_h, step_cnt_h};

  typedef struct {
    logic        start;
    logic [1:0]  op;
    logic [1:0]  dsize;
    logic        stall;
    logic        sign;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [13];

  initial clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  function automatic logic [15:0] mk(input logic [3:0] alp, input logic [1:0] dq,
                                     input logic f, input logic s, input logic b,
                                     input logic d, input logic [5:0] c);
    return {alp, dq, f, s, b, d, c};
  endfunction

  task automatic check(input string name, input logic [15:0] exp, input logic [15:0] mask);
    n_checks++;
    if (((obs & mask) !== (exp & mask)) || (obs[11:10] == 2'b00)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, obs, exp, mask);
    end
  endtask

  task automatic drive(input logic st, input logic [1:0] op, input logic [1:0] ds,
                       input logic stl, input logic sg);
    start_h    = st;
    op_h       = op;
    dsize_h    = ds;
    stall_h    = stl;
    alu_sign_h = sg;
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_h  = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_state", mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0), FULL);
    reset_h = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();

    // MUL byte, with starts pulsed in STEP and DONE, and stall in DONE/IDLE.
    for (int i = 0; i < 13; i++)
      tbl[i] = '{start: 1'b0, op: 2'b00, dsize: 2'b00, stall: 1'b0, sign: 1'b0,
                 exp: mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[0].start = 1'b1;
    tbl[1].exp   = mk(4'b0111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 6'd7);
    for (int k = 2; k <= 9; k++)
      tbl[k].exp = mk(4'b0111, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 6'(9 - k));
    tbl[5].start  = 1'b1;
    tbl[5].op     = 2'b01;
    tbl[5].dsize  = 2'b10;
    tbl[10].exp   = mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0);
    tbl[10].start = 1'b1;
    tbl[10].stall = 1'b1;
    tbl[11].stall = 1'b1;

    for (int i = 0; i < 13; i++) begin
      check($sformatf("mul_byte_c%0d", i), tbl[i].exp, FULL);
      drive(tbl[i].start, tbl[i].op, tbl[i].dsize, tbl[i].stall, tbl[i].sign);
      tick();
    end

    // DIV long with alternating sign.
    drive(1'b1, 2'b01, 2'b10, 1'b0, 1'b0);
    tick();
    check("div_pre", mk(4'b1011, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 6'd31), FULL);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    for (int k = 2; k <= 33; k++) begin
      logic s;
      s = (k == 2) ? 1'b1 : ((k - 1) % 2 == 1) ? 1'b0 : 1'b1;
      check($sformatf("div_step_c%0d", k), mk(4'b1011, 2'b01, 1'b0, s, 1'b1, 1'b0, 6'(33 - k)), FULL);
      drive(1'b0, 2'b00, 2'b00, 1'b0, (k % 2 == 1));
      tick();
    end
    check("div_done", mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0), FULL);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    check("div_idle", mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0), FULL);

    // REM word, negative sign in the last STEP restores via add in FIX.
    drive(1'b1, 2'b11, 2'b01, 1'b0, 1'b0);
    tick();
    check("rem_pre", mk(4'b1011, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 6'd15), FULL);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    for (int k = 2; k <= 17; k++) begin
      check($sformatf("rem_step_c%0d", k), mk(4'b1011, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 6'(17 - k)), FULL);
      drive(1'b0, 2'b00, 2'b00, 1'b0, (k == 17));
      tick();
    end
    check("rem_fix", mk(4'b1110, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0), FULL);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    check("rem_done", mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0), FULL);
    tick();

    // DIVDBL byte, stall held three cycles at count 4.
    drive(1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
    tick();
    check("dbl_pre", mk(4'b1001, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 6'd7), FULL);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    for (int k = 2; k <= 12; k++) begin
      if (k >= 6 && k <= 8)
        check($sformatf("dbl_stall_c%0d", k), mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4), NOSUB);
      else if (k <= 5)
        check($sformatf("dbl_step_c%0d", k), mk(4'b1001, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 6'(9 - k)), FULL);
      else
        check($sformatf("dbl_step_c%0d", k), mk(4'b1001, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 6'(12 - k)), FULL);
      drive(1'b0, 2'b00, 2'b00, (k >= 5 && k <= 7), 1'b0);
      tick();
    end
    check("dbl_done", mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0), FULL);
    tick();

    // Reset mid-sequence of a long MUL, then restart immediately.
    drive(1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
    tick();
    check("rst_mul_pre", mk(4'b0111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 6'd31), FULL);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    for (int k = 2; k <= 23; k++) begin
      check($sformatf("rst_mul_c%0d", k), mk(4'b0111, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 6'(33 - k)), FULL);
      tick();
    end
    reset_h = 1'b1;
    tick();
    check("rst_mid_idle", mk(4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0), FULL);
    reset_h = 1'b0;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    check("rst_restart_pre", mk(4'b0111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 6'd7), FULL);
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    begin
      int w;
      w = 0;
      while (!done_h && w < 20) begin
        tick();
        w++;
      end
      n_checks++;
      if (!done_h || w != 9) begin
        n_fail++;
        $display("FAIL restart_latency: done_h=%0b after %0d cycles, expected done_h=1 after 9", done_h, w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alkmdseq.md
Name: alkmdseq

Overview:
- Multiply/divide step sequencer for the ALK slice of the DPM.
- Driven by one start pulse from the microsequencer; steps the Q shift in/out routing and ALU add/subtract for N iterations. N is set by DSIZE.
- Drives the ALPCTL decode lines (mul/div/divdbl/rem), the DQ Q-shift decode lines and ALUSHF force-SOUT0 that the Q shift I/O routing consumes.
- Reports busy/done back to the microsequencer.

Parameters:
- CNT_W, 6, width of iteration counter (must hold 32).

Ports:
- clk_h  input  1  ALK clock
- reset_h  input  1  synchronous reset, active high
- start_h  input  1  one-cycle start request; honoured only in IDLE
- op_h  input  2  operation, sampled with start: 00 MUL, 01 DIV, 10 DIVDBL, 11 REM
- dsize_h  input  2  data size, sampled with start: 00 byte (N=8), 01 word (N=16), 1x long (N=32)
- stall_h  input  1  freeze request from microsequencer
- alu_sign_h  input  1  sign of current ALU partial remainder
- alpctl_mul_l  output  1  ALPCTL MUL decode, active low
- alpctl_div_l  output  1  ALPCTL DIV decode, active low
- alpctl_divdbl_l  output  1  ALPCTL DIVDBL decode, active low
- alpctl_rem_l  output  1  ALPCTL REM decode, active low
- dq_q_shl_l  output  1  DQ Q shift-left select, active low
- dq_q_shr_l  output  1  DQ Q shift-right select, active low
- alushf_force_sout0_h  output  1  force 0 into shift-out
- alu_sub_h  output  1  ALU subtract (1) / add (0)
- busy_h  output  1  sequence in progress
- done_h  output  1  one-cycle completion pulse
- step_cnt_h  output  CNT_W  remaining iterations

Behaviour:
- All outputs registered, Moore-decoded from state.
- Reset values: all _l outputs 1; all _h outputs 0; step_cnt_h 0; state IDLE.
- Reset wins over every other input, including reset mid-sequence: IDLE and all outputs inactive after the next edge.
- States and transitions:
  - IDLE: start_h -> PRE. Latch op and dsize. step_cnt <= N-1.
  - PRE: one cycle. alushf_force_sout0_h=1 (clears shift-in bit). Asserts the op's ALPCTL line(s). No Q shift. busy_h=1. -> STEP.
  - STEP: one iteration per unstalled cycle. When step_cnt==0 and not stalled: MUL/DIV/DIVDBL -> DONE; REM -> FIX. Otherwise step_cnt decrements.
  - FIX (REM only): one cycle. alpctl_rem_l=0. alu_sub_h=0 if alu_sign_h=1 (restore remainder), else alu_sub_h=1. -> DONE.
  - DONE: done_h=1, busy_h=0, controls inactive, step_cnt_h=0. -> IDLE.
- STEP decode by op:
  - MUL: alpctl_mul_l=0, dq_q_shr_l=0, alu_sub_h=0.
  - DIV: alpctl_div_l=0, dq_q_shl_l=0.
  - DIVDBL: alpctl_div_l=0, alpctl_divdbl_l=0, dq_q_shl_l=0.
  - REM: as DIV.
- alu_sub_h for divides (non-restoring): 1 on first STEP cycle; thereafter equals ~alu_sign_h from the previous cycle.
- Stall (stall_h=1):
  - Honoured in PRE, STEP and FIX.
  - State, step_cnt and the sign history are frozen.
  - All ALPCTL/DQ/ALUSHF outputs are forced inactive in the same registered cycle, so Q does not shift.
  - busy_h stays 1.
  - On release, resumes with identical outputs.
  - stall_h is ignored in IDLE and DONE.
- start_h while busy or in DONE is ignored; no queueing.
- dsize 11 is treated as long (N=32).
- Latency from start cycle to done_h: N+2 cycles for MUL/DIV/DIVDBL, N+3 for REM, plus stalled cycles.
- Exactly one of dq_q_shl_l / dq_q_shr_l may be low at any time; never both.

Test Plan:
- Reset, then MUL byte start at cycle 0 -> PRE in cycle 1 with force_sout0=1; dq_q_shr_l=0 and alpctl_mul_l=0 for cycles 2-9; step_cnt 7->0; done_h in cycle 10 only.
- DIV long, alu_sign_h toggling 0,1,0,... -> 32 STEP cycles with dq_q_shl_l=0; alu_sub_h pattern 1 then ~previous sign; done_h at cycle 34.
- REM word, alu_sign_h=1 in last STEP -> FIX cycle with alpctl_rem_l=0, alu_sub_h=0; done_h at cycle 19.
- DIVDBL byte, stall_h high for 3 cycles at STEP count 4 -> controls inactive, step_cnt held at 4, busy_h=1; resumes; done_h at cycle 13.
- Reset asserted at STEP count 10 of a long MUL -> next cycle all _l=1, busy_h=0, step_cnt_h=0; new start accepted the following cycle.
- start_h pulsed during STEP and during DONE -> ignored; exactly one done_h per accepted start.
